// File: rtl/pkg_agencia.sv
// Shared types for the vault alarm path: siren controller states, also shown on the LEDs.
package pkg_agencia;

  typedef enum logic [1:0] {
    REPOUSO    = 2'd0,
    DISPARO    = 2'd1,
    SUSTENTA   = 2'd2,
    SILENCIADO = 2'd3
  } estado_sirene_t;

  // Counter width able to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gerador_bipe.sv
// Beep phase generator: fase stays at each level for BEEP_HALF enabled cycles.
module gerador_bipe
  import pkg_agencia::*;
#(
  parameter int unsigned BEEP_HALF = 4
) (
  input  logic clk_2,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic fase
);

  localparam int unsigned    CW       = cnt_width(BEEP_HALF);
  localparam logic [CW-1:0]  CNT_LAST = CW'(BEEP_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fase_q, fase_d;

  // NOTE: every variable gets a default before any branch, so no path can
  // leave it unassigned and imply a latch.
  always_comb begin
    cnt_d  = cnt_q;
    fase_d = fase_q;
    if (restart) begin
      cnt_d  = '0;
      fase_d = 1'b1;
    end else if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        fase_d = ~fase_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      fase_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fase_q <= fase_d;
    end
  end

  assign fase = fase_q;

endmodule

// File: rtl/controle_sirene.sv
// Siren controller: beeps while the vault alarm is active, holds after it drops,
// can be silenced by the manager and counts alarm events with saturation.
module controle_sirene
  import pkg_agencia::*;
#(
  parameter int unsigned BEEP_HALF   = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned NBITS_EVT   = 8
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 alarme,
  input  logic                 reconhece,
  input  logic                 zera_contagem,
  output logic                 sirene,
  output logic [1:0]           estado,
  output logic [NBITS_EVT-1:0] eventos
);

  localparam int unsigned   HW        = cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  estado_sirene_t       state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [NBITS_EVT-1:0] evt_q, evt_d;
  logic                 beep_restart, beep_enable, fase;

  gerador_bipe #(
    .BEEP_HALF (BEEP_HALF)
  ) u_bipe (
    .clk_2   (clk_2),
    .reset   (reset),
    .restart (beep_restart),
    .enable  (beep_enable),
    .fase    (fase)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    evt_d        = evt_q;
    beep_restart = 1'b0;
    beep_enable  = 1'b0;

    unique case (state_q)
      REPOUSO: begin
        if (alarme) begin
          state_d      = DISPARO;
          beep_restart = 1'b1;
          if (evt_q != '1) evt_d = evt_q + NBITS_EVT'(1);
        end
      end
      DISPARO: begin
        beep_enable = 1'b1;
        if (reconhece) begin
          state_d = SILENCIADO;
        end else if (!alarme) begin
          state_d = SUSTENTA;
          hold_d  = HOLD_LAST;
        end
      end
      SUSTENTA: begin
        beep_enable = 1'b1;
        if (reconhece)          state_d = SILENCIADO;
        else if (alarme)        state_d = DISPARO;   // same event resumes, phase untouched
        else if (hold_q == '0)  state_d = REPOUSO;
        else                    hold_d  = hold_q - HW'(1);
      end
      SILENCIADO: begin
        if (!alarme) state_d = REPOUSO;
      end
      default: state_d = REPOUSO;
    endcase

    if (zera_contagem) evt_d = '0;
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= REPOUSO;
      hold_q  <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      evt_q   <= evt_d;
    end
  end

  assign sirene  = fase & ((state_q == DISPARO) | (state_q == SUSTENTA));
  assign estado  = state_q;
  assign eventos = evt_q;

endmodule

// File: tb/tb_controle_sirene.sv
// Bench for controle_sirene: directed scenarios plus random traffic against a
// cycle-level behavioural model of the siren rules.
module tb_controle_sirene;

  localparam int BEEP_HALF   = 4;
  localparam int HOLD_CYCLES = 16;
  localparam int EVT_MAX     = 255;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       alarme = 1'b0, reconhece = 1'b0, zera_contagem = 1'b0;
  logic       sirene;
  logic [1:0] estado;
  logic [7:0] eventos;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0 idle, 1 alarm, 2 holding, 3 silenced.
  int m_mode, m_evt, m_beep, m_hold_left;
  logic cur_a;

  controle_sirene #(
    .BEEP_HALF   (BEEP_HALF),
    .HOLD_CYCLES (HOLD_CYCLES),
    .NBITS_EVT   (8)
  ) dut (
    .clk_2         (clk_2),
    .reset         (reset),
    .alarme        (alarme),
    .reconhece     (reconhece),
    .zera_contagem (zera_contagem),
    .sirene        (sirene),
    .estado        (estado),
    .eventos       (eventos)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_evt = 0; m_beep = 0; m_hold_left = 0;
  endtask

  task automatic model_edge(input logic a, input logic r, input logic z);
    case (m_mode)
      0: if (a) begin
        m_mode = 1;
        m_beep = 0;
        if (m_evt < EVT_MAX) m_evt++;
      end
      1: begin
        m_beep++;
        if (r) m_mode = 3;
        else if (!a) begin m_mode = 2; m_hold_left = HOLD_CYCLES; end
      end
      2: begin
        m_beep++;
        if (r) m_mode = 3;
        else if (a) m_mode = 1;
        else begin
          m_hold_left--;
          if (m_hold_left == 0) m_mode = 0;
        end
      end
      default: if (!a) m_mode = 0;
    endcase
    if (z) m_evt = 0;
  endtask

  function automatic int exp_sirene();
    if (m_mode != 1 && m_mode != 2) return 0;
    return ((m_beep / BEEP_HALF) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic compare_all();
    check("estado", int'(estado), m_mode);
    check("sirene", int'(sirene), exp_sirene());
    check("eventos", int'(eventos), m_evt);
  endtask

  task automatic tick(input logic a, input logic r, input logic z);
    alarme = a; reconhece = r; zera_contagem = z;
    @(posedge clk_2);
    model_edge(a, r, z);
    #2;
    compare_all();
  endtask

  // Reset pulse placed mid-cycle; outputs must clear before any clock edge.
  task automatic mid_reset();
    #1 reset = 1'b1;
    #1;
    model_reset();
    check("rst_estado", int'(estado), 0);
    check("rst_sirene", int'(sirene), 0);
    check("rst_eventos", int'(eventos), 0);
    #1 reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_2);
    #2;
    compare_all();
    reset = 1'b0;

    // Alarm, beep pattern, then hold for the full hold time and back to idle.
    tick(0, 0, 0);
    repeat (12) tick(1, 0, 0);
    repeat (HOLD_CYCLES + 3) tick(0, 0, 0);

    // Acknowledge while alarmed, release, new event.
    repeat (3) tick(1, 0, 0);
    tick(1, 1, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);

    // Return to alarm partway through the hold, then let it time out.
    tick(0, 0, 0);
    repeat (10) tick(0, 0, 0);
    repeat (5) tick(1, 0, 0);
    repeat (HOLD_CYCLES + 2) tick(0, 0, 0);

    // Saturate the event counter, then clear it on an event edge.
    for (int i = 0; i < 258; i++) begin
      tick(1, 0, 0);
      tick(1, 1, 0);
      tick(0, 0, 0);
    end
    tick(1, 0, 1);
    tick(1, 0, 0);

    // Reset while sounding.
    tick(1, 0, 0);
    check("pre_rst_sirene", int'(sirene), 1);
    mid_reset();
    repeat (3) tick(0, 0, 0);

    // Random traffic.
    cur_a = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) cur_a = ~cur_a;
      tick(cur_a, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) mid_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
